rv_pc_v3: RTL and testbench

Parametrised next-generation fetch PC unit for the RV32 core. It computes JAL, JALR and conditional-branch targets at execute and captures redirects that arrive while fetch is busy or stalled, applying them later instead of dropping them. It also detects misaligned targets, redirects traps to a fixed vector, and issues a one-cycle IF/ID flush. It sits between the execute stage (redirect source) and the instruction fetch port.

---
 rtl/rv_pc_pkg.sv | 32 +++
 rtl/rv_pc_v3_if.sv | 37 +++
 rtl/rv_target_gen.sv | 52 +++++
 rtl/rv_pc_v3.sv | 102 ++++++++++
 tb/tb_rv_pc_v3.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pc_pkg.sv
// Shared types and immediate decoders for the rv_pc_v3 fetch PC unit.
package rv_pc_pkg;

  typedef enum logic [1:0] {
    JAL    = 2'd0,
    JALR   = 2'd1,
    BRANCH = 2'd2,
    NONE   = 2'd3
  } redirect_kind_e;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } pc_state_e;

  // Decoders take instr[31:7]; the opcode bits carry no immediate content.
  // Results are signed, so callers sign-extend them to XLEN with a size cast.
  typedef logic signed [31:0] simm_t;

  function automatic simm_t imm_i(input logic [31:7] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic simm_t imm_b(input logic [31:7] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  function automatic simm_t imm_j(input logic [31:7] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/rv_pc_v3_if.sv
// Execute/fetch-side bundle of the PC unit; clk and rst stay outside.
interface rv_pc_v3_if #(
  parameter int unsigned XLEN = 32
);
  logic            enable_i;
  logic            busy_i;
  logic            stall_i;
  logic            redirect_valid_i;
  logic [1:0]      redirect_kind_i;
  logic            branch_taken_i;
  logic [XLEN-1:0] execute_pc_i;
  logic [31:0]     instr_i;
  logic [XLEN-1:0] reg_s1_i;
  logic            trap_req_i;

  logic [XLEN-1:0] pc_o;
  logic [XLEN-1:0] return_addr_o;
  logic            flush_o;
  logic            pending_o;
  logic            misalign_exc_o;
  logic [XLEN-1:0] misalign_addr_o;
  logic            halt_o;

  modport master (
    output enable_i, busy_i, stall_i, redirect_valid_i, redirect_kind_i,
           branch_taken_i, execute_pc_i, instr_i, reg_s1_i, trap_req_i,
    input  pc_o, return_addr_o, flush_o, pending_o, misalign_exc_o,
           misalign_addr_o, halt_o
  );

  modport slave (
    input  enable_i, busy_i, stall_i, redirect_valid_i, redirect_kind_i,
           branch_taken_i, execute_pc_i, instr_i, reg_s1_i, trap_req_i,
    output pc_o, return_addr_o, flush_o, pending_o, misalign_exc_o,
           misalign_addr_o, halt_o
  );
endinterface

// File: rtl/rv_target_gen.sv
// Combinational control-transfer target, take decision and alignment check.
module rv_target_gen
  import rv_pc_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter bit          COMPRESSED = 1'b0
) (
  input  logic           redirect_valid_i,
  input  redirect_kind_e redirect_kind_i,
  input  logic           branch_taken_i,
  input  logic [XLEN-1:0] execute_pc_i,
  input  logic [31:7]    instr_i,
  input  logic [XLEN-1:0] reg_s1_i,
  output logic [XLEN-1:0] target_o,
  output logic           take_o,
  output logic           mis_o
);

  localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

  logic [XLEN-1:0] immJ;
  logic [XLEN-1:0] immB;
  logic [XLEN-1:0] immI;

  assign immJ = XLEN'(imm_j(instr_i));
  assign immB = XLEN'(imm_b(instr_i));
  assign immI = XLEN'(imm_i(instr_i));

  always_comb begin
    target_o = '0;
    take_o   = 1'b0;
    case (redirect_kind_i)
      JAL: begin
        target_o = execute_pc_i + immJ;
        take_o   = redirect_valid_i;
      end
      JALR: begin
        target_o = (reg_s1_i + immI) & JALR_MASK;
        take_o   = redirect_valid_i;
      end
      BRANCH: begin
        target_o = execute_pc_i + immB;
        take_o   = redirect_valid_i & branch_taken_i;
      end
      default: ;
    endcase
  end

  // Compressed mode only needs halfword alignment; otherwise word alignment.
  assign mis_o = take_o & (COMPRESSED ? target_o[0] : (target_o[1:0] != 2'b00));

endmodule

// File: rtl/rv_pc_v3.sv
// Fetch PC unit: sequential stepping, redirects, deferred redirects while
// fetch cannot advance, trap/misalign vectoring and IF/ID flush.
module rv_pc_v3
  import rv_pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter bit              COMPRESSED   = 1'b0
) (
  input logic       clk,
  input logic       rst,
  rv_pc_v3_if.slave bus
);

  logic [XLEN-1:0] target;
  logic            take;
  logic            mis;
  logic            advance;
  logic            evt;
  logic            misReport;
  logic [XLEN-1:0] effTarget_d;

  pc_state_e       state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pendPc_q;
  logic            flush_q;
  logic            misExc_q;
  logic [XLEN-1:0] misAddr_q;

  rv_target_gen #(
    .XLEN       (XLEN),
    .COMPRESSED (COMPRESSED)
  ) u_target_gen (
    .redirect_valid_i (bus.redirect_valid_i),
    .redirect_kind_i  (redirect_kind_e'(bus.redirect_kind_i)),
    .branch_taken_i   (bus.branch_taken_i),
    .execute_pc_i     (bus.execute_pc_i),
    .instr_i          (bus.instr_i[31:7]),
    .reg_s1_i         (bus.reg_s1_i),
    .target_o         (target),
    .take_o           (take),
    .mis_o            (mis)
  );

  assign advance     = bus.enable_i & ~bus.busy_i & ~bus.stall_i;
  assign evt         = bus.trap_req_i | take;
  assign misReport   = mis & ~bus.trap_req_i;
  assign effTarget_d = (bus.trap_req_i | mis) ? TRAP_VECTOR : target;

  // In PEND a fresh event supersedes the captured target; if fetch can also
  // advance that cycle the fresh target goes straight to the PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      pc_q      <= RESET_VECTOR;
      pendPc_q  <= '0;
      flush_q   <= 1'b0;
      misExc_q  <= 1'b0;
      misAddr_q <= '0;
    end else begin
      flush_q  <= evt;
      misExc_q <= misReport;
      if (misReport) begin
        misAddr_q <= target;
      end
      case (state_q)
        RUN: begin
          if (evt && advance) begin
            pc_q <= effTarget_d;
          end else if (evt) begin
            pendPc_q <= effTarget_d;
            state_q  <= PEND;
          end else if (advance) begin
            pc_q <= pc_q + XLEN'(4);
          end
        end
        PEND: begin
          if (evt && advance) begin
            pc_q    <= effTarget_d;
            state_q <= RUN;
          end else if (evt) begin
            pendPc_q <= effTarget_d;
          end else if (advance) begin
            pc_q    <= pendPc_q;
            state_q <= RUN;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign bus.pc_o            = pc_q;
  assign bus.return_addr_o   = bus.execute_pc_i + XLEN'(4);
  assign bus.flush_o         = flush_q;
  assign bus.pending_o       = (state_q == PEND);
  assign bus.misalign_exc_o  = misExc_q;
  assign bus.misalign_addr_o = misAddr_q;
  assign bus.halt_o          = ~bus.enable_i;

endmodule

// File: tb/tb_rv_pc_v3.sv
// Drives a word-aligned and a compressed-mode rv_pc_v3 with the same stimulus
// and checks both against a behavioural model of the PC rules.
module tb_rv_pc_v3;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] TRAP = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable, busy, stall, rValid, taken, trapReq;
  logic [1:0]  kind;
  logic [31:0] epc, instr, rs1;

  int testsRun    = 0;
  int testsFailed = 0;
  bit checkEn     = 1'b0;

  logic [31:0] pcOut[2], raOut[2], maOut[2];
  logic        flOut[2], peOut[2], meOut[2], haOut[2];

  // Behavioural model state, index 0 = word aligned, 1 = compressed mode
  logic [31:0] mPc[2], mPendPc[2], mMisAddr[2];
  bit          mPend[2], mFlush[2], mMisExc[2];

  rv_pc_v3_if #(.XLEN(XLEN)) bus [2] ();

  for (genvar g = 0; g < 2; g++) begin : gDut
    assign bus[g].enable_i         = enable;
    assign bus[g].busy_i           = busy;
    assign bus[g].stall_i          = stall;
    assign bus[g].redirect_valid_i = rValid;
    assign bus[g].redirect_kind_i  = kind;
    assign bus[g].branch_taken_i   = taken;
    assign bus[g].execute_pc_i     = epc;
    assign bus[g].instr_i          = instr;
    assign bus[g].reg_s1_i         = rs1;
    assign bus[g].trap_req_i       = trapReq;
    assign pcOut[g] = bus[g].pc_o;
    assign raOut[g] = bus[g].return_addr_o;
    assign flOut[g] = bus[g].flush_o;
    assign peOut[g] = bus[g].pending_o;
    assign meOut[g] = bus[g].misalign_exc_o;
    assign maOut[g] = bus[g].misalign_addr_o;
    assign haOut[g] = bus[g].halt_o;

    rv_pc_v3 #(
      .XLEN         (XLEN),
      .RESET_VECTOR (32'h0),
      .TRAP_VECTOR  (TRAP),
      .COMPRESSED   (g == 1)
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus[g])
    );
  end

  always #5 clk = ~clk;

  function automatic logic [31:0] encJ(input logic [31:0] imm);
    logic [31:0] w;
    w = 32'h0000_006F;
    w[31] = imm[20]; w[30:21] = imm[10:1]; w[20] = imm[11]; w[19:12] = imm[19:12];
    return w;
  endfunction

  function automatic logic [31:0] encB(input logic [31:0] imm);
    logic [31:0] w;
    w = 32'h0000_0063;
    w[31] = imm[12]; w[30:25] = imm[10:5]; w[11:8] = imm[4:1]; w[7] = imm[11];
    return w;
  endfunction

  function automatic logic [31:0] encI(input logic [31:0] imm);
    logic [31:0] w;
    w = 32'h0000_0067;
    w[31:20] = imm[11:0];
    return w;
  endfunction

  // Immediates rebuilt as unsigned field values, then sign-corrected by subtraction
  task automatic refTarget(output bit take, output logic [31:0] tgt);
    int unsigned j, b, i;
    j = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    b = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    i = instr[31:20];
    if (j >= 32'h0010_0000) j = j - 32'h0020_0000;
    if (b >= 32'h0000_1000) b = b - 32'h0000_2000;
    if (i >= 32'h0000_0800) i = i - 32'h0000_1000;
    take = rValid && (kind == 2'd0 || kind == 2'd1 || (kind == 2'd2 && taken));
    case (kind)
      2'd0:    tgt = epc + j;
      2'd1:    tgt = (rs1 + i) & 32'hFFFF_FFFE;
      2'd2:    tgt = epc + b;
      default: tgt = 32'h0;
    endcase
  endtask

  always @(posedge clk or posedge rst) begin : modelBlk
    bit take, mis, evt, adv;
    logic [31:0] tgt, eff;
    if (rst) begin
      for (int m = 0; m < 2; m++) begin
        mPc[m] = 32'h0; mPendPc[m] = 32'h0; mMisAddr[m] = 32'h0;
        mPend[m] = 1'b0; mFlush[m] = 1'b0; mMisExc[m] = 1'b0;
      end
    end else begin
      refTarget(take, tgt);
      adv = enable && !busy && !stall;
      evt = trapReq || take;
      for (int m = 0; m < 2; m++) begin
        mis = take && ((m == 1) ? (tgt[0] != 1'b0) : (tgt[1:0] != 2'b00));
        eff = (trapReq || mis) ? TRAP : tgt;
        mFlush[m]  = evt;
        mMisExc[m] = mis && !trapReq;
        if (mis && !trapReq) mMisAddr[m] = tgt;
        if (evt && adv) begin
          mPc[m] = eff; mPend[m] = 1'b0;
        end else if (evt) begin
          mPendPc[m] = eff; mPend[m] = 1'b1;
        end else if (adv) begin
          mPc[m] = mPend[m] ? mPendPc[m] : mPc[m] + 32'd4;
          mPend[m] = 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      for (int m = 0; m < 2; m++) begin
        checkOutput($sformatf("cyc pc[%0d]", m), pcOut[m], mPc[m]);
        checkOutput($sformatf("cyc flush[%0d]", m), 32'(flOut[m]), 32'(mFlush[m]));
        checkOutput($sformatf("cyc pending[%0d]", m), 32'(peOut[m]), 32'(mPend[m]));
        checkOutput($sformatf("cyc misexc[%0d]", m), 32'(meOut[m]), 32'(mMisExc[m]));
        checkOutput($sformatf("cyc misaddr[%0d]", m), maOut[m], mMisAddr[m]);
        checkOutput($sformatf("cyc retaddr[%0d]", m), raOut[m], epc + 32'd4);
        checkOutput($sformatf("cyc halt[%0d]", m), 32'(haOut[m]), 32'(!enable));
      end
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit v, input logic [1:0] k, input bit t,
                               input logic [31:0] pcE, input logic [31:0] ins,
                               input logic [31:0] s1, input bit trap);
    rValid = v; kind = k; taken = t; epc = pcE; instr = ins; rs1 = s1; trapReq = trap;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    enable = 1'b1; busy = 1'b0; stall = 1'b0;
    idle();
    #2 rst = 1'b1;
    checkEn = 1'b1;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      checkOutput("reset pc", pcOut[m], 32'h0);
      checkOutput("reset flush", 32'(flOut[m]), 32'h0);
      checkOutput("reset pending", 32'(peOut[m]), 32'h0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("release pc 0", pcOut[0], 32'h0);
    stepCycle();
    checkOutput("release pc 4", pcOut[0], 32'h4);
    stepCycle();
    checkOutput("release pc 8", pcOut[0], 32'h8);
    checkOutput("model pc 8", mPc[0], 32'h8);

    applyStimulus(1'b1, 2'd0, 1'b0, 32'h100, encJ(32'h20), 32'h0, 1'b0);
    #1 checkOutput("jal return_addr", raOut[0], 32'h104);
    stepCycle();
    checkOutput("jal pc", pcOut[0], 32'h120);
    checkOutput("jal flush", 32'(flOut[0]), 32'h1);
    checkOutput("model jal pc", mPc[1], 32'h120);
    idle();
    stepCycle();
    checkOutput("jal flush drop", 32'(flOut[0]), 32'h0);

    busy = 1'b1;
    applyStimulus(1'b1, 2'd2, 1'b1, 32'h200, encB(32'hFFFF_FFF0), 32'h0, 1'b0);
    stepCycle();
    checkOutput("busy pc held", pcOut[0], 32'h124);
    checkOutput("busy pending", 32'(peOut[0]), 32'h1);
    checkOutput("busy flush", 32'(flOut[0]), 32'h1);
    idle();
    stepCycle();
    checkOutput("busy flush once", 32'(flOut[0]), 32'h0);
    stepCycle();
    checkOutput("busy pc still held", pcOut[0], 32'h124);
    busy = 1'b0;
    stepCycle();
    checkOutput("busy release pc", pcOut[0], 32'h1F0);
    checkOutput("busy release pending", 32'(peOut[0]), 32'h0);

    applyStimulus(1'b1, 2'd1, 1'b0, 32'h0, encI(32'h4), 32'h1003, 1'b0);
    stepCycle();
    checkOutput("jalr compressed pc", pcOut[1], 32'h1006);
    checkOutput("jalr aligned pc", pcOut[0], TRAP);
    checkOutput("jalr misexc", 32'(meOut[0]), 32'h1);
    checkOutput("jalr misaddr", maOut[0], 32'h1006);
    checkOutput("model jalr misaddr", mMisAddr[0], 32'h1006);
    idle();
    stepCycle();
    checkOutput("jalr misexc drop", 32'(meOut[0]), 32'h0);
    checkOutput("jalr misaddr hold", maOut[0], 32'h1006);

    applyStimulus(1'b1, 2'd0, 1'b0, 32'h100, encJ(32'h22), 32'h0, 1'b1);
    stepCycle();
    checkOutput("trap pc", pcOut[0], TRAP);
    checkOutput("trap misexc", 32'(meOut[0]), 32'h0);
    checkOutput("trap flush", 32'(flOut[0]), 32'h1);
    idle();
    stepCycle();
    checkOutput("trap flush drop", 32'(flOut[0]), 32'h0);

    enable = 1'b0;
    applyStimulus(1'b1, 2'd2, 1'b1, 32'h310, encB(32'hFFFF_FFF0), 32'h0, 1'b0);
    #1 checkOutput("halt", 32'(haOut[0]), 32'h1);
    stepCycle();
    checkOutput("halted pending", 32'(peOut[0]), 32'h1);
    checkOutput("halted pc", pcOut[0], 32'h104);
    enable = 1'b1;
    idle();
    stepCycle();
    checkOutput("halted resume pc", pcOut[0], 32'h300);

    applyStimulus(1'b1, 2'd0, 1'b0, 32'hFFFF_FFFC, encJ(32'h0), 32'h0, 1'b0);
    stepCycle();
    checkOutput("wrap top", pcOut[0], 32'hFFFF_FFFC);
    idle();
    stepCycle();
    checkOutput("wrap zero", pcOut[0], 32'h0);

    busy = 1'b1;
    applyStimulus(1'b1, 2'd0, 1'b0, 32'h100, encJ(32'h20), 32'h0, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 2'd0, 1'b0, 32'h100, encJ(32'h100), 32'h0, 1'b0);
    stepCycle();
    checkOutput("latest wins flush", 32'(flOut[0]), 32'h1);
    busy = 1'b0;
    idle();
    stepCycle();
    checkOutput("latest wins pc", pcOut[0], 32'h200);

    busy = 1'b1;
    applyStimulus(1'b1, 2'd0, 1'b0, 32'h100, encJ(32'h40), 32'h0, 1'b0);
    stepCycle();
    rst = 1'b1;
    #1;
    checkOutput("async reset pending", 32'(peOut[0]), 32'h0);
    checkOutput("async reset pc", pcOut[0], 32'h0);
    stepCycle();
    rst = 1'b0; busy = 1'b0;
    idle();

    for (int c = 0; c < 3000; c++) begin
      stepCycle();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 199) == 0) rst = 1'b1;
      enable  = ($urandom_range(0, 9) != 0);
      busy    = ($urandom_range(0, 3) == 0);
      stall   = ($urandom_range(0, 4) == 0);
      rValid  = ($urandom_range(0, 2) == 0);
      kind    = 2'($urandom_range(0, 3));
      taken   = 1'($urandom_range(0, 1));
      epc     = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      instr   = $urandom;
      rs1     = $urandom;
      trapReq = ($urandom_range(0, 19) == 0);
    end
    stepCycle();
    rst = 1'b0;
    idle();
    stepCycle();
    @(negedge clk);
    #1 checkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
